// File: rtl/full_add_pkg.sv
// Shared arithmetic constants for the full adder family.
// Used only for elaboration-time parameter checks.
package full_add_pkg;

  localparam int FULL_ADD_MAX_WIDTH = 64;

  function automatic bit width_ok(int w);
    return (w >= 1) && (w <= FULL_ADD_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_add_behavioral_bit.sv
// One-bit full adder cell.
// Chained by the top level to form a ripple-carry adder.
module full_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // sum and majority carry of the three inputs
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/full_add_behavioral.sv
// Ripple-carry full adder with combinational result
// and a one-cycle registered copy.
module full_add_behavioral
  import full_add_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q,
  output logic             overflow_q,
  output logic             out_valid
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("full_add_behavioral: WIDTH out of range");
  end

  logic [WIDTH:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_add_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  // carry out of MSB; signed overflow when MSB
  // carry-in and carry-out disagree
  always_comb begin
    carry_out = c[WIDTH];
    overflow  = c[WIDTH] ^ c[WIDTH-1];
  end

  // data stage: loads on valid, holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (in_valid) begin
      sum_q       <= sum;
      carry_out_q <= carry_out;
      overflow_q  <= overflow;
    end
  end

  // valid pulse follows in_valid by one cycle
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

endmodule

// File: tb/tb_full_add_behavioral.sv
// Self-checking bench for full_add_behavioral.
// Covers WIDTH=1 truth table and WIDTH=8 paths.
module tb_full_add_behavioral;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a1, b1, ci1;
  logic       s1, co1, ov1, sq1, coq1, ovq1, ovld1;

  logic [7:0] a8, b8, s8, sq8;
  logic       ci8, iv8, co8, ov8, coq8, ovq8, ovld8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_add_behavioral #(.WIDTH(1)) u_w1 (
    .clk         (clk),
    .rst         (rst),
    .a           (a1),
    .b           (b1),
    .carry_in    (ci1),
    .in_valid    (1'b0),
    .sum         (s1),
    .carry_out   (co1),
    .overflow    (ov1),
    .sum_q       (sq1),
    .carry_out_q (coq1),
    .overflow_q  (ovq1),
    .out_valid   (ovld1)
  );

  full_add_behavioral #(.WIDTH(8)) u_w8 (
    .clk         (clk),
    .rst         (rst),
    .a           (a8),
    .b           (b8),
    .carry_in    (ci8),
    .in_valid    (iv8),
    .sum         (s8),
    .carry_out   (co8),
    .overflow    (ov8),
    .sum_q       (sq8),
    .carry_out_q (coq8),
    .overflow_q  (ovq8),
    .out_valid   (ovld8)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_sum [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                             2'b01, 2'b10, 2'b10, 2'b11};
  logic       tt_ov  [8] = '{1'b0, 1'b1, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b0};

  logic [8:0] m_full;
  logic       m_ov;
  logic [7:0] q_sum;
  logic       q_co, q_ov, q_vld;

  initial begin
    a1 = 0; b1 = 0; ci1 = 0;
    a8 = 0; b8 = 0; ci8 = 0; iv8 = 0;

    // reset state
    tick();
    tick();
    check("rst_sum_q", 32'(sq8), 0);
    check("rst_co_q", 32'(coq8), 0);
    check("rst_ov_q", 32'(ovq8), 0);
    check("rst_vld", 32'(ovld8), 0);
    check("rst_vld_w1", 32'(ovld1), 0);

    // WIDTH=1 truth table, no clock involved
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a1, b1, ci1} = v;
      #1;
      check($sformatf("w1_sum_%0d", i),
            32'({co1, s1}), 32'(tt_sum[i]));
      check($sformatf("w1_ov_%0d", i),
            32'(ov1), 32'(tt_ov[i]));
    end

    // WIDTH=8 combinational boundaries (during reset)
    a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
    #1;
    check("ff_sum", 32'(s8), 32'h00);
    check("ff_co", 32'(co8), 1);
    check("ff_ov", 32'(ov8), 0);
    a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0;
    #1;
    check("7f_sum", 32'(s8), 32'h80);
    check("7f_co", 32'(co8), 0);
    check("7f_ov", 32'(ov8), 1);

    // registered op
    rst = 1'b0;
    tick();
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; iv8 = 1'b1;
    tick();
    check("reg_vld", 32'(ovld8), 1);
    check("reg_sum_q", 32'(sq8), 32'h47);
    check("reg_co_q", 32'(coq8), 0);
    check("reg_ov_q", 32'(ovq8), 0);

    // hold for 3 cycles while comb tracks
    iv8 = 1'b0;
    a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0;
    #1;
    check("hold_sum0", 32'(s8), 32'h03);
    tick();
    check("hold_vld0", 32'(ovld8), 0);
    check("hold_sq0", 32'(sq8), 32'h47);
    a8 = 8'hF0; b8 = 8'h20; ci8 = 1'b0;
    #1;
    check("hold_sum1", 32'({co8, s8}), 32'h110);
    tick();
    check("hold_vld1", 32'(ovld8), 0);
    check("hold_sq1", 32'(sq8), 32'h47);
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b1;
    #1;
    check("hold_sum2", 32'({co8, s8}), 32'h101);
    check("hold_ov2", 32'(ov8), 1);
    tick();
    check("hold_vld2", 32'(ovld8), 0);
    check("hold_sq2", 32'(sq8), 32'h47);
    check("hold_coq2", 32'(coq8), 0);
    check("hold_ovq2", 32'(ovq8), 0);

    // load a result with carry/overflow set, then reset
    iv8 = 1'b1;
    tick();
    check("pre_rst_sq", 32'(sq8), 32'h01);
    check("pre_rst_coq", 32'(coq8), 1);
    check("pre_rst_ovq", 32'(ovq8), 1);
    rst = 1'b1;
    a8 = 8'hC8; b8 = 8'h64; ci8 = 1'b0;
    tick();
    check("mid_rst_sq", 32'(sq8), 0);
    check("mid_rst_coq", 32'(coq8), 0);
    check("mid_rst_ovq", 32'(ovq8), 0);
    check("mid_rst_vld", 32'(ovld8), 0);
    check("mid_rst_sum", 32'({co8, s8}), 32'h12C);
    rst = 1'b0;
    tick();
    check("post_rst_vld", 32'(ovld8), 1);
    check("post_rst_sq", 32'(sq8), 32'h2C);

    // random sweep against a reference model
    q_sum = sq8; q_co = coq8; q_ov = ovq8; q_vld = ovld8;
    for (int n = 0; n < 1200; n++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      ci8 = 1'($urandom);
      iv8 = 1'($urandom);
      m_full = {1'b0, a8} + {1'b0, b8} + 9'(ci8);
      m_ov = (a8[7] == b8[7]) && (m_full[7] != a8[7]);
      #1;
      check("rnd_comb", 32'({co8, s8}), 32'(m_full));
      check("rnd_ov", 32'(ov8), 32'(m_ov));
      if (iv8) begin
        q_sum = m_full[7:0];
        q_co  = m_full[8];
        q_ov  = m_ov;
      end
      q_vld = iv8;
      tick();
      check("rnd_reg",
            32'({ovld8, ovq8, coq8, sq8}),
            32'({q_vld, q_ov, q_co, q_sum}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_add_behavioral.md
# full_add_behavioral

Full adder with a combinational result path and a one-cycle registered copy of the result. With the default `WIDTH = 1` it is the classic 1-bit full adder, and it exhausts all 8 input combinations at its combinational outputs. Wider settings chain identical bit cells into a ripple-carry adder. It sits in combinational datapaths as an arithmetic primitive, and the registered side serves pipelined consumers.

## Interface
Parameters:
- `WIDTH`, default 1: operand and sum width in bits, ≥1.

Ports:
- `clk` input 1: single clock; all registers update on its rising edge.
- `rst` input 1: synchronous, active-high reset; affects registered outputs only.
- `a` input WIDTH: operand A, unsigned.
- `b` input WIDTH: operand B, unsigned.
- `carry_in` input 1: carry into bit 0.
- `in_valid` input 1: qualifies `a`, `b` and `carry_in` for capture into the registered stage.
- `sum` output WIDTH: combinational sum, `(a + b + carry_in) mod 2^WIDTH`.
- `carry_out` output 1: combinational carry out of bit WIDTH-1.
- `overflow` output 1: combinational signed overflow; carry into MSB XOR carry out of MSB.
- `sum_q` output WIDTH: registered `sum`.
- `carry_out_q` output 1: registered `carry_out`.
- `overflow_q` output 1: registered `overflow`.
- `out_valid` output 1: registered `in_valid`.

## Operation
- Bit cell i computes `s[i] = a[i] ^ b[i] ^ c[i]` and `c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]`.
- `c[0] = carry_in` and `carry_out = c[WIDTH]`.
- `{carry_out, sum}` equals the (WIDTH+1)-bit unsigned sum `a + b + carry_in`; no saturation, wrap modulo 2^WIDTH.
- `overflow = c[WIDTH] ^ c[WIDTH-1]`.
  - For WIDTH = 1, `c[0]` is `carry_in`, so `overflow = carry_out ^ carry_in`.
- Combinational outputs depend only on `a`, `b` and `carry_in`. They are independent of `clk`, `rst` and `in_valid`, and are valid whenever inputs are known, including during reset.
- Registered stage on each rising `clk` edge:
  - `rst = 1`: `sum_q`, `carry_out_q`, `overflow_q` and `out_valid` all load 0.
  - `rst = 0`, `in_valid = 1`: `sum_q`, `carry_out_q` and `overflow_q` load the current combinational values; `out_valid` loads 1.
  - `rst = 0`, `in_valid = 0`: data registers hold their values; `out_valid` loads 0.
- No backpressure: the consumer must accept `out_valid` pulses as they occur.
- Any input bit X/Z propagates to the affected outputs. No X-masking is performed.

## Timing
- Combinational path: zero-cycle latency. Outputs settle in the same simulation time step as an input change, with no clock required.
- Registered path: 1-cycle latency from an edge sampling `in_valid = 1` to `out_valid = 1` with matching data.
- Throughput: one operation per cycle.
- Reset values: `sum_q = 0`, `carry_out_q = 0`, `overflow_q = 0`, `out_valid = 0`.
- Reset mid-operation: `rst` wins over `in_valid` on the same edge. The in-flight result is discarded and the stage reads all zeros on the following cycle.
- Reset release: the first edge with `rst = 0` and `in_valid = 1` produces `out_valid = 1` one cycle later.
- Critical path: the WIDTH-cell ripple chain, from `carry_in` or `a[0]`/`b[0]` to `carry_out`/`overflow`.

## Structure
- No shared package types needed.
- A shared arithmetic package may hold a `FULL_ADD_MAX_WIDTH` constant used for elaboration-time checks.
- Sub-module `full_add_bit`: 1-bit cell with ports `a`, `b`, `cin`, `s`, `cout`.
  - Instantiated WIDTH times via a generate loop, with the carry chained.
- Top level holds the carry vector `c[WIDTH:0]`, the overflow XOR and the output register stage.
- Elaboration check: error if `WIDTH < 1`.

## Test plan
- WIDTH=1, apply all 8 `{a,b,carry_in}` combos 000…111, one per time step with no clock. Required `{carry_out,sum}` in order: 00, 01, 01, 10, 01, 10, 10, 11.
- WIDTH=8, combinational:
  - a=8'hFF, b=8'h00, carry_in=1 → sum=8'h00, carry_out=1, overflow=0.
  - a=8'h7F, b=8'h01, carry_in=0 → sum=8'h80, carry_out=0, overflow=1.
- WIDTH=8, registered: drive in_valid=1 with a=8'h12, b=8'h34, carry_in=1 at edge N. Required at edge N+1: out_valid=1, sum_q=8'h47, carry_out_q=0.
- Hold behaviour: in_valid=0 for 3 cycles after a valid op → out_valid=0 and sum_q/carry_out_q/overflow_q unchanged, while `sum` tracks new inputs immediately.
- Reset: assert rst together with in_valid=1 → next cycle all registered outputs are 0; combinational `sum`/`carry_out` remain correct throughout reset.
- Randomized WIDTH=8 sweep (≥1000 vectors): `{carry_out,sum} == a+b+carry_in` every step, and registered outputs match the previous valid step.
